// File: rtl/ahb_pkg.sv
// ============================================================
// Package : ahb_pkg
// Brief   : Shared AHB-lite transfer and response encodings.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

endpackage : ahb_pkg

`default_nettype wire

// File: rtl/ahb_rr_arbiter_rr_pick.sv
// ============================================================
// Module  : rr_pick
// Brief   : Rotate-priority pick; first request after i_ptr wins.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_valid
);

    // Scan i_ptr+1 .. i_ptr+NUM_REQ so the last winner has lowest priority.
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!o_valid && i_req[PTR_W'((int'(i_ptr) + k) % NUM_REQ)]) begin
                o_grant[PTR_W'((int'(i_ptr) + k) % NUM_REQ)] = 1'b1;
                o_valid = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
// ============================================================
// Module  : ahb_rr_arbiter
// Brief   : Round-robin AHB-lite arbiter sharing the APB bridge port.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int MAX_HOLD    = 8
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic [NUM_MASTERS-1:0]           HBUSREQ,
    input  logic [2*NUM_MASTERS-1:0]         M_HTRANS,
    input  logic [ADDRWIDTH*NUM_MASTERS-1:0] M_HADDR,
    input  logic [NUM_MASTERS-1:0]           M_HWRITE,
    input  logic [3*NUM_MASTERS-1:0]         M_HSIZE,
    input  logic [4*NUM_MASTERS-1:0]         M_HPROT,
    input  logic [DATAWIDTH*NUM_MASTERS-1:0] M_HWDATA,
    output logic [NUM_MASTERS-1:0]           HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0]   HMASTER,
    output logic                             HSEL,
    output logic [1:0]                       HTRANS,
    output logic [ADDRWIDTH-1:0]             HADDR,
    output logic                             HWRITE,
    output logic [2:0]                       HSIZE,
    output logic [3:0]                       HPROT,
    output logic [DATAWIDTH-1:0]             HWDATA,
    input  logic                             S_HREADYOUT,
    input  logic [DATAWIDTH-1:0]             S_HRDATA,
    input  logic                             S_HRESP,
    output logic                             HREADY,
    output logic [DATAWIDTH-1:0]             HRDATA,
    output logic                             HRESP
);

    import ahb_pkg::*;

    localparam int c_MW = $clog2(NUM_MASTERS);
    localparam int c_HW = $clog2(MAX_HOLD + 1);

    logic [c_MW-1:0]      r_hmaster;
    logic [c_MW-1:0]      r_hmaster_d;
    logic [c_MW-1:0]      r_rr_ptr;
    logic [c_HW-1:0]      r_hold_cnt;

    logic [1:0]           w_htrans [NUM_MASTERS];
    logic [ADDRWIDTH-1:0] w_haddr  [NUM_MASTERS];
    logic [2:0]           w_hsize  [NUM_MASTERS];
    logic [3:0]           w_hprot  [NUM_MASTERS];
    logic [DATAWIDTH-1:0] w_hwdata [NUM_MASTERS];

    logic [1:0]             w_owner_trans;
    logic                   w_others_req;
    logic [c_HW-1:0]        w_hold_next;
    logic                   w_arb_event;
    logic [NUM_MASTERS-1:0] w_pick_req;
    logic [NUM_MASTERS-1:0] w_pick_grant;
    logic                   w_pick_valid;
    logic [c_MW-1:0]        w_pick_idx;
    logic                   w_switch;

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_htrans[gi] = M_HTRANS[2*gi +: 2];
        assign w_haddr[gi]  = M_HADDR[ADDRWIDTH*gi +: ADDRWIDTH];
        assign w_hsize[gi]  = M_HSIZE[3*gi +: 3];
        assign w_hprot[gi]  = M_HPROT[4*gi +: 4];
        assign w_hwdata[gi] = M_HWDATA[DATAWIDTH*gi +: DATAWIDTH];
    end

    always_comb begin
        HGRANT            = '0;
        HGRANT[r_hmaster] = 1'b1;
    end

    assign HMASTER = r_hmaster;
    assign HTRANS  = w_htrans[r_hmaster];
    assign HSEL    = HTRANS[1];
    assign HADDR   = w_haddr[r_hmaster];
    assign HWRITE  = M_HWRITE[r_hmaster];
    assign HSIZE   = w_hsize[r_hmaster];
    assign HPROT   = w_hprot[r_hmaster];
    assign HWDATA  = w_hwdata[r_hmaster_d];

    assign HREADY  = S_HREADYOUT;
    assign HRDATA  = S_HRDATA;
    assign HRESP   = S_HRESP;

    assign w_owner_trans = w_htrans[r_hmaster];
    assign w_others_req  = |(HBUSREQ & ~HGRANT);

    // The phase sampled on this edge counts, so an owner facing competition
    // gets exactly MAX_HOLD address phases (BUSY included) before handing over.
    assign w_hold_next = (w_owner_trans != HTRANS_IDLE && r_hold_cnt != c_HW'(MAX_HOLD))
                         ? r_hold_cnt + 1'b1 : r_hold_cnt;

    assign w_arb_event = !HBUSREQ[r_hmaster]
                      || (w_others_req && w_owner_trans == HTRANS_IDLE)
                      || (w_others_req && w_hold_next == c_HW'(MAX_HOLD));

    // The current owner competes only when nobody else is asking.
    assign w_pick_req = w_others_req ? (HBUSREQ & ~HGRANT) : HBUSREQ;

    rr_pick #(
        .NUM_REQ (NUM_MASTERS),
        .PTR_W   (c_MW)
    ) u_rr_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_pick_grant[i]) begin
                w_pick_idx = c_MW'(i);
            end
        end
    end

    assign w_switch = w_arb_event && w_pick_valid && (w_pick_idx != r_hmaster);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hmaster   <= '0;
            r_hmaster_d <= '0;
            r_rr_ptr    <= c_MW'(NUM_MASTERS - 1);
            r_hold_cnt  <= '0;
        end else if (HREADY) begin
            r_hmaster_d <= r_hmaster;
            if (w_switch) begin
                r_hmaster  <= w_pick_idx;
                r_rr_ptr   <= w_pick_idx;
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= w_hold_next;
            end
        end
    end

endmodule : ahb_rr_arbiter

`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
// ============================================================
// Module  : tb_ahb_rr_arbiter
// Brief   : Self-checking bench with a behavioural arbitration model.
// Revision: 1.0 - initial release
// ============================================================
`default_nettype none

module tb_ahb_rr_arbiter;

    import ahb_pkg::*;

    localparam int N    = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXH = 8;
    localparam int MW   = 2;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    HBUSREQ;
    logic [2*N-1:0]  M_HTRANS;
    logic [AW*N-1:0] M_HADDR;
    logic [N-1:0]    M_HWRITE;
    logic [3*N-1:0]  M_HSIZE;
    logic [4*N-1:0]  M_HPROT;
    logic [DW*N-1:0] M_HWDATA;
    logic [N-1:0]    HGRANT;
    logic [MW-1:0]   HMASTER;
    logic            HSEL;
    logic [1:0]      HTRANS;
    logic [AW-1:0]   HADDR;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [3:0]      HPROT;
    logic [DW-1:0]   HWDATA;
    logic            S_HREADYOUT;
    logic [DW-1:0]   S_HRDATA;
    logic            S_HRESP;
    logic            HREADY;
    logic [DW-1:0]   HRDATA;
    logic            HRESP;

    ahb_rr_arbiter #(
        .NUM_MASTERS (N),
        .ADDRWIDTH   (AW),
        .DATAWIDTH   (DW),
        .MAX_HOLD    (MAXH)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HBUSREQ     (HBUSREQ),
        .M_HTRANS    (M_HTRANS),
        .M_HADDR     (M_HADDR),
        .M_HWRITE    (M_HWRITE),
        .M_HSIZE     (M_HSIZE),
        .M_HPROT     (M_HPROT),
        .M_HWDATA    (M_HWDATA),
        .HGRANT      (HGRANT),
        .HMASTER     (HMASTER),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HPROT       (HPROT),
        .HWDATA      (HWDATA),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRDATA    (S_HRDATA),
        .S_HRESP     (S_HRESP),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    // Model state: address owner, data-phase owner, last winner, phases used.
    int m_owner;
    int m_downer;
    int m_ptr;
    int m_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("hgrant",  64'(HGRANT),  64'd1 << m_owner);
        check("hmaster", 64'(HMASTER), 64'(m_owner));
        check("htrans",  64'(HTRANS),  64'(M_HTRANS[2*m_owner +: 2]));
        check("hsel",    64'(HSEL),    64'(M_HTRANS[2*m_owner + 1]));
        check("haddr",   64'(HADDR),   64'(M_HADDR[AW*m_owner +: AW]));
        check("hwrite",  64'(HWRITE),  64'(M_HWRITE[m_owner]));
        check("hsize",   64'(HSIZE),   64'(M_HSIZE[3*m_owner +: 3]));
        check("hprot",   64'(HPROT),   64'(M_HPROT[4*m_owner +: 4]));
        check("hwdata",  64'(HWDATA),  64'(M_HWDATA[DW*m_downer +: DW]));
        check("hready",  64'(HREADY),  64'(S_HREADYOUT));
        check("hrdata",  64'(HRDATA),  64'(S_HRDATA));
        check("hresp",   64'(HRESP),   64'(S_HRESP));
    endtask

    // Apply the arbitration rules for one rising edge, using the inputs as sampled there.
    task automatic model_step();
        int others;
        int tr;
        int phases;
        int win;
        int c;
        bit ev;
        if (HRESET) begin
            m_owner  = 0;
            m_downer = 0;
            m_ptr    = N - 1;
            m_hold   = 0;
            return;
        end
        if (!S_HREADYOUT) return;
        others = 0;
        for (int i = 0; i < N; i++) begin
            if (i != m_owner && HBUSREQ[i]) others++;
        end
        tr     = int'(M_HTRANS[2*m_owner +: 2]);
        phases = (tr != 0) ? ((m_hold + 1 > MAXH) ? MAXH : m_hold + 1) : m_hold;
        ev     = !HBUSREQ[m_owner] || (others > 0 && (tr == 0 || phases == MAXH));
        win    = -1;
        if (ev && others > 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && c != m_owner && HBUSREQ[c]) win = c;
            end
        end
        m_downer = m_owner;
        if (win >= 0) begin
            m_owner = win;
            m_ptr   = win;
            m_hold  = 0;
        end else begin
            m_hold = phases;
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        #1;
        compare_model();
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
    endtask

    task automatic set_m(input int i, input logic req, input logic [1:0] tr,
                         input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] d);
        HBUSREQ[i]            = req;
        M_HTRANS[2*i +: 2]    = tr;
        M_HADDR[AW*i +: AW]   = a;
        M_HWRITE[i]           = wr;
        M_HWDATA[DW*i +: DW]  = d;
    endtask

    task automatic quiet_masters();
        for (int i = 0; i < N; i++) set_m(i, 1'b0, HTRANS_IDLE, '0, 1'b0, 32'hA000_0000 + 32'(i));
        M_HSIZE     = '0;
        M_HPROT     = '0;
        S_HREADYOUT = 1'b1;
        S_HRDATA    = '0;
        S_HRESP     = c_HRESP_OKAY;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        quiet_masters();
        tick();
        HRESET = 1'b0;
    endtask

    initial begin
        m_owner  = 0;
        m_downer = 0;
        m_ptr    = N - 1;
        m_hold   = 0;
        HRESET   = 1'b1;
        HBUSREQ  = '0;
        M_HTRANS = '0;
        M_HADDR  = '0;
        M_HWRITE = '0;
        M_HWDATA = '0;
        quiet_masters();
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
        do_reset();

        // Reset state with no requests.
        #1;
        check("rst_hgrant",  64'(HGRANT),  64'h1);
        check("rst_hmaster", 64'(HMASTER), 64'h0);
        check("rst_hsel",    64'(HSEL),    64'h0);
        check("rst_hready",  64'(HREADY),  64'h1);

        // Single master 2 write of 0xDEADBEEF to 0x0040.
        set_m(2, 1'b1, HTRANS_NONSEQ, 16'h0040, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("m2_pre_grant", 64'(HGRANT), 64'h1);
        tick();
        #1;
        check("m2_hgrant",  64'(HGRANT),  64'h4);
        check("m2_hmaster", 64'(HMASTER), 64'h2);
        check("m2_htrans",  64'(HTRANS),  64'h2);
        check("m2_haddr",   64'(HADDR),   64'h0040);
        check("m2_hwrite",  64'(HWRITE),  64'h1);
        tick();
        set_m(2, 1'b1, HTRANS_IDLE, 16'h0000, 1'b0, 32'hDEAD_BEEF);
        #1;
        check("m2_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
        tick();

        // All four masters stream NONSEQ: each owns exactly MAXH cycles in turn.
        do_reset();
        for (int i = 0; i < N; i++) set_m(i, 1'b1, HTRANS_NONSEQ, 16'(16'h100 * i), 1'b0, 32'hA000_0000 + 32'(i));
        for (int k = 0; k < 5 * N * MAXH; k++) begin
            #1;
            check("rotation", 64'(HMASTER), 64'((k / MAXH) % N));
            tick();
        end

        // Master 1 read stalled by the bridge while master 3 waits.
        do_reset();
        set_m(1, 1'b1, HTRANS_NONSEQ, 16'h0100, 1'b0, 32'hA000_0001);
        tick();
        tick();
        set_m(1, 1'b1, HTRANS_IDLE, 16'h0000, 1'b0, 32'hA000_0001);
        set_m(3, 1'b1, HTRANS_NONSEQ, 16'h0300, 1'b0, 32'hA000_0003);
        S_HREADYOUT = 1'b0;
        S_HRDATA    = 32'h1234_5678;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_hmaster", 64'(HMASTER), 64'h1);
            check("stall_hready",  64'(HREADY),  64'h0);
            tick();
        end
        S_HREADYOUT = 1'b1;
        #1;
        check("stall_hrdata",  64'(HRDATA),  64'h1234_5678);
        check("stall_hmaster", 64'(HMASTER), 64'h1);
        tick();
        #1;
        check("after_stall_hmaster", 64'(HMASTER), 64'h3);
        check("after_stall_hgrant",  64'(HGRANT),  64'h8);

        // Owner 3 drops its request with nobody else asking: grant parks.
        set_m(1, 1'b0, HTRANS_IDLE, 16'h0000, 1'b0, 32'hA000_0001);
        set_m(3, 1'b0, HTRANS_IDLE, 16'h0000, 1'b0, 32'hA000_0003);
        tick();
        #1;
        check("park_hmaster", 64'(HMASTER), 64'h3);
        check("park_hgrant",  64'(HGRANT),  64'h8);
        tick();
        set_m(0, 1'b1, HTRANS_NONSEQ, 16'h0000, 1'b0, 32'hA000_0000);
        set_m(2, 1'b1, HTRANS_NONSEQ, 16'h0200, 1'b0, 32'hA000_0002);
        tick();
        #1;
        check("park_ptr_next", 64'(HMASTER), 64'h0);

        // Reset during master 2's data phase.
        do_reset();
        set_m(2, 1'b1, HTRANS_NONSEQ, 16'h0040, 1'b1, 32'hDEAD_BEEF);
        tick();
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        check("midrst_hgrant",  64'(HGRANT),  64'h1);
        check("midrst_hmaster", 64'(HMASTER), 64'h0);
        check("midrst_hwdata",  64'(HWDATA),  64'hA000_0000);
        tick();

        // Random traffic with bridge stalls and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            HRESET      = ($urandom_range(0, 199) == 0);
            HBUSREQ     = 4'($urandom);
            M_HTRANS    = 8'($urandom);
            M_HADDR     = {$urandom, $urandom};
            M_HWRITE    = 4'($urandom);
            M_HSIZE     = 12'($urandom);
            M_HPROT     = 16'($urandom);
            M_HWDATA    = {$urandom, $urandom, $urandom, $urandom};
            S_HREADYOUT = ($urandom_range(0, 3) != 0);
            S_HRDATA    = $urandom;
            S_HRESP     = 1'($urandom);
            tick();
        end

        // Busy bus: almost always everyone requesting with active transfers.
        HRESET = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            HBUSREQ = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < N; i++) M_HTRANS[2*i +: 2] = 2'($urandom_range(1, 3));
            M_HADDR     = {$urandom, $urandom};
            M_HWDATA    = {$urandom, $urandom, $urandom, $urandom};
            S_HREADYOUT = ($urandom_range(0, 4) != 0);
            S_HRDATA    = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ahb_rr_arbiter

`default_nettype wire
